// File: rtl/axi_burst_engine.sv
// AXI-style burst engine: buffers write data in a FIFO and issues one
// address/data beat per transfer for FIXED, INCR and WRAP bursts.
// Ports: aclk/resetn (sync, active-high); req_* burst request handshake;
// wvalid/wdata/wready write-data push; beat_* downstream beat handshake;
// busy (burst running), err (rejected request pulse), fill (occupancy).
module axi_burst_engine #(
    parameter int SIZE   = 4,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [5:0]        req_len,
    input  logic [2:0]        req_size,
    input  logic [1:0]        req_type,
    input  logic              wvalid,
    input  logic [SIZE*8-1:0] wdata,
    output logic              wready,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [SIZE*8-1:0] beat_data,
    output logic              beat_last,
    output logic              busy,
    output logic              err,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic [5:0]        len_q, len_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        type_q, type_d;
    logic              err_q, err_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [SIZE*8-1:0] mem_q [DEPTH];

    logic              push, pop, illegal;
    logic [7:0]        req_bytes;
    logic [ADDR_W-1:0] wrap_mask, beat_bytes;
    logic [ADDR_W-1:0] incr_addr, wrap_addr;

    assign req_ready  = (state_q == IDLE) & ~resetn;
    assign busy       = (state_q == RUN);
    assign beat_valid = busy & (fill_q != '0);
    assign beat_addr  = addr_q;
    assign beat_data  = mem_q[rd_ptr_q];
    assign beat_last  = busy & (cnt_q == len_q);
    assign err        = err_q;
    assign wready     = (fill_q != FW'(DEPTH));
    assign fill       = fill_q;

    assign push = wvalid & wready;
    assign pop  = beat_valid & beat_ready;

    assign req_bytes = 8'd1 << req_size;
    assign illegal =
        (req_type == 2'b11) |
        ({24'd0, req_bytes} > 32'(SIZE)) |
        ((req_type == 2'b10) &
         (req_len != 6'd1) & (req_len != 6'd3) &
         (req_len != 6'd7) & (req_len != 6'd15)) |
        ((req_type == 2'b10) &
         ((req_addr & ADDR_W'(req_bytes - 8'd1)) != '0));

    // Low bits inside the wrap container come from the incremented
    // address, high bits stay at the container boundary.
    assign wrap_mask  = ((ADDR_W'(req_len) + ADDR_W'(1)) << req_size)
                      - ADDR_W'(1);
    assign beat_bytes = ADDR_W'(1) << size_q;
    assign incr_addr  = (addr_q & ~(beat_bytes - ADDR_W'(1)))
                      + beat_bytes;
    assign wrap_addr  = (addr_q & ~mask_q)
                      | ((addr_q + beat_bytes) & mask_q);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        type_d   = type_q;
        err_d    = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        addr_d  = req_addr;
                        mask_d  = wrap_mask;
                        len_d   = req_len;
                        size_d  = req_size;
                        type_d  = req_type;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                if (pop) begin
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                        unique case (type_q)
                            2'b01:   addr_d = incr_addr;
                            2'b10:   addr_d = wrap_addr;
                            default: addr_d = addr_q;
                        endcase
                    end
                end
            end
        endcase
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            mask_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            size_q   <= '0;
            type_q   <= '0;
            err_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            type_q   <= type_d;
            err_q    <= err_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: doc/axi_burst_engine.md
AXI_BURST_ENGINE -- requirements
Module: axi_burst_engine

Interface
REQ-001 Parameter SIZE, default 4, bytes per data beat; data width is SIZE*8 bits.
REQ-002 Parameter ADDR_W, default 32, address width in bits.
REQ-003 Parameter DEPTH, default 16, write-data buffer entries; power of two, at least 2.
REQ-004 aclk  input  1  single clock; all logic on rising edge.
REQ-005 resetn  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  burst request present.
REQ-007 req_ready  output  1  burst request accepted this cycle when high with req_valid.
REQ-008 req_addr  input  ADDR_W  burst start address.
REQ-009 req_len  input  6  beats minus one (1..64 beats).
REQ-010 req_size  input  3  log2 bytes per beat.
REQ-011 req_type  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-012 wvalid  input  1  write data present.
REQ-013 wdata  input  SIZE*8  write data.
REQ-014 wready  output  1  buffer can accept wdata.
REQ-015 beat_valid  output  1  beat address/data valid.
REQ-016 beat_ready  input  1  downstream accepts beat.
REQ-017 beat_addr  output  ADDR_W  address of current beat.
REQ-018 beat_data  output  SIZE*8  data of current beat (buffer head).
REQ-019 beat_last  output  1  current beat is final of burst.
REQ-020 busy  output  1  burst in progress.
REQ-021 err  output  1  one-cycle pulse on rejected request.
REQ-022 fill  output  log2(DEPTH)+1  buffer occupancy.

Function
REQ-023 FSM states IDLE and RUN; req_ready = 1 only in IDLE; busy = 1 only in RUN.
REQ-024 IDLE & req_valid: latch addr/len/size/type; go RUN next cycle, unless illegal.
REQ-025 Illegal request: req_type = 11; 2^req_size > SIZE; WRAP with req_len+1 not in {2,4,8,16}; WRAP with req_addr not aligned to 2^req_size. Illegal request is consumed, err pulses next cycle, state stays IDLE.
REQ-026 beat_valid = RUN & fill != 0; beat_data = buffer head; beat outputs hold stable while beat_valid & !beat_ready.
REQ-027 Beat transfer = beat_valid & beat_ready; pops buffer and advances address and beat counter.
REQ-028 FIXED: every beat uses req_addr.
REQ-029 INCR: beat 0 = req_addr; beat n = (req_addr aligned down to 2^req_size) + n*2^req_size, modulo 2^ADDR_W.
REQ-030 WRAP: container = (req_len+1)*2^req_size bytes; boundary = req_addr aligned down to container; address increments by 2^req_size and wraps to boundary on reaching boundary+container.
REQ-031 beat_last = 1 when beat counter = latched req_len; transfer of that beat returns FSM to IDLE next cycle; req_ready high in that next cycle.
REQ-032 Buffer is a FIFO of DEPTH entries; wready = (fill != DEPTH); push = wvalid & wready; accepted independently of FSM state.
REQ-033 Simultaneous push and pop: fill unchanged, data order preserved; at full, wready low, so only pop occurs.
REQ-034 Empty buffer in RUN: beat_valid low, address and counter hold; burst resumes on next push.
REQ-035 Latency: pushed word visible on beat_data no earlier than the cycle after the push; first beat_valid no earlier than the cycle after request acceptance.

Reset
REQ-036 resetn high: state IDLE, buffer emptied, fill = 0, beat_valid = 0, beat_last = 0, busy = 0, err = 0, wready = 1, beat_addr = 0, counters = 0.
REQ-037 resetn high mid-burst: remaining beats are abandoned, buffered data is discarded, and no beat is issued in the cycle after reset.
REQ-038 req_ready = 0 while resetn is high.

Verification
REQ-039 INCR, SIZE=4, addr 0x100, len 3, size 2, 4 words preloaded, beat_ready=1 -> addrs 0x100,0x104,0x108,0x10C on consecutive cycles; beat_last on 4th only.
REQ-040 WRAP, addr 0x38, len 3, size 2 -> addrs 0x38,0x3C,0x30,0x34; beat_last on 0x34.
REQ-041 FIXED, addr 0x20, len 1, beat_ready toggling 1,0,1 -> both beats at 0x20; beat held stable during stall; data order matches pushes.
REQ-042 Illegal requests (type 11; WRAP len 2; size 3 with SIZE=4) -> err pulse, no beat_valid, FSM stays IDLE.
REQ-043 Fill DEPTH words with beat_ready=0 -> wready=0 and fill=DEPTH; push+pop same cycle -> fill unchanged; run to empty mid-burst -> beat_valid low until next push.
REQ-044 Reset asserted on beat 2 of a 4-beat INCR burst -> next cycle fill=0, busy=0, beat_valid=0; new request accepted after reset release.
